// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for sharing the single-port data memory between the LSU (m0) and the debug/DMA loader (m1).
// The memory access happens in the cycle after the request is sampled; read data returns one cycle after gnt. Requesters hold req until they see gnt.
module dmem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_rw,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                rr_last_q, rr_last_d;
   logic                cmd_we_q, cmd_we_d;
   logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
   logic                rvalid0_q, rvalid1_q;
   logic [DATA_W-1:0]   rdata0_q, rdata1_q;
   logic                access;
   logic                elig0, elig1;
   logic                win_id;

   assign access = (state_q == ACCESS);
   assign m0_gnt = access && !owner_q;
   assign m1_gnt = access && owner_q;

   // A requester being granted this cycle is still showing the req we are consuming.
   assign elig0  = m0_req && !m0_gnt;
   assign elig1  = m1_req && !m1_gnt;
   assign win_id = (elig0 && elig1) ? ~rr_last_q : elig1;

   always_comb begin
      state_d     = IDLE;
      owner_d     = owner_q;
      rr_last_d   = rr_last_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      if (elig0 || elig1) begin
         state_d     = ACCESS;
         owner_d     = win_id;
         rr_last_d   = win_id;
         cmd_we_d    = win_id ? m1_we    : m0_we;
         cmd_addr_d  = win_id ? m1_addr  : m0_addr;
         cmd_wdata_d = win_id ? m1_wdata : m0_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         rr_last_q   <= 1'b1;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_last_q   <= rr_last_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         rvalid0_q   <= access && !owner_q && !cmd_we_q;
         rvalid1_q   <= access && owner_q && !cmd_we_q;
         if (access && !owner_q && !cmd_we_q) rdata0_q <= mem_rdata;
         if (access && owner_q && !cmd_we_q)  rdata1_q <= mem_rdata;
      end
   end

   // Memory-side outputs are gated by state so reset drops mem_rw without waiting for an edge.
   assign mem_rw    = access && cmd_we_q;
   assign mem_addr  = access ? {{(32-ADDR_W){1'b0}}, cmd_addr_q} : 32'd0;
   assign mem_wdata = access ? cmd_wdata_q : '0;

   assign m0_rvalid = rvalid0_q;
   assign m1_rvalid = rvalid1_q;
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed requester traffic against a behavioural single-port memory,
// with expected grants and read returns queued at issue time and checked by a negedge monitor.
module tb_dmem_arbiter;

   typedef struct {
      int          cyc;
      bit          who;
      bit          rw;
      logic [31:0] addr;
      logic [31:0] wdata;
   } gexp_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } rexp_t;

   logic        clk;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [9:0]  m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_rw;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [1024] = '{default: 32'd0};
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   gexp_t       exp_g[$];
   rexp_t       exp_r0[$];
   rexp_t       exp_r1[$];

   dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign mem_rdata = mem[mem_addr[9:0]];
   always @(posedge clk) if (mem_rw) mem[mem_addr[9:0]] <= mem_wdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit who, input bit req, input bit we, input int addr, input logic [31:0] wd);
      if (who) begin
         m1_req = req; m1_we = we; m1_addr = 10'(addr); m1_wdata = wd;
      end else begin
         m0_req = req; m0_we = we; m0_addr = 10'(addr); m0_wdata = wd;
      end
   endtask

   task automatic push_g(input int c, input bit who, input bit rw, input int addr, input logic [31:0] wd);
      gexp_t g;
      g.cyc = c; g.who = who; g.rw = rw; g.addr = 32'(addr); g.wdata = wd;
      exp_g.push_back(g);
   endtask

   task automatic push_r(input int c, input bit who, input logic [31:0] d);
      rexp_t r;
      r.cyc = c; r.data = d;
      if (who) exp_r1.push_back(r);
      else     exp_r0.push_back(r);
   endtask

   // One isolated access; caller is just past a rising edge, in cycle c.
   task automatic single(input bit who, input bit we, input int addr, input logic [31:0] wd, input logic [31:0] rexp);
      int c;
      c = cyc;
      push_g(c + 1, who, we, addr, wd);
      if (!we) push_r(c + 2, who, rexp);
      drive(who, 1'b1, we, addr, wd);
      tick();
      tick();
      drive(who, 1'b0, 1'b0, 0, 32'd0);
   endtask

   task automatic monitor();
      gexp_t g;
      rexp_t r;
      forever begin
         @(negedge clk);
         if (m0_gnt && m1_gnt) begin
            chk("dual_gnt", 64'({m1_gnt, m0_gnt}), 64'd1);
         end else if (m0_gnt || m1_gnt) begin
            if (exp_g.size() == 0) begin
               chk("unexpected_gnt", 64'({m1_gnt, m0_gnt}), 64'd0);
            end else begin
               g = exp_g.pop_front();
               chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
               chk("gnt_who", 64'(m1_gnt), 64'(g.who));
               chk("gnt_mem_rw", 64'(mem_rw), 64'(g.rw));
               chk("gnt_mem_addr", 64'(mem_addr), 64'(g.addr));
               if (g.rw) chk("gnt_mem_wdata", 64'(mem_wdata), 64'(g.wdata));
            end
         end else begin
            chk("idle_mem_rw", 64'(mem_rw), 64'd0);
            chk("idle_mem_addr", 64'(mem_addr), 64'd0);
            chk("idle_mem_wdata", 64'(mem_wdata), 64'd0);
         end
         if (m0_rvalid) begin
            if (exp_r0.size() == 0) chk("unexpected_m0_rvalid", 64'(m0_rvalid), 64'd0);
            else begin
               r = exp_r0.pop_front();
               chk("m0_rvalid_cycle", 64'(cyc), 64'(r.cyc));
               chk("m0_rdata", 64'(m0_rdata), 64'(r.data));
            end
         end
         if (m1_rvalid) begin
            if (exp_r1.size() == 0) chk("unexpected_m1_rvalid", 64'(m1_rvalid), 64'd0);
            else begin
               r = exp_r1.pop_front();
               chk("m1_rvalid_cycle", 64'(cyc), 64'(r.cyc));
               chk("m1_rdata", 64'(m1_rdata), 64'(r.data));
            end
         end
      end
   endtask

   initial begin
      int c;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 0, 32'd0);
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m0_gnt", 64'(m0_gnt), 64'd0);
      chk("rst_m1_gnt", 64'(m1_gnt), 64'd0);
      chk("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
      chk("rst_m1_rvalid", 64'(m1_rvalid), 64'd0);
      chk("rst_m0_rdata", 64'(m0_rdata), 64'd0);
      chk("rst_m1_rdata", 64'(m1_rdata), 64'd0);
      chk("rst_mem_rw", 64'(mem_rw), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // m0 write then read-back of the same word
      single(1'b0, 1'b1, 5, 32'hDEADBEEF, 32'd0);
      single(1'b0, 1'b0, 5, 32'd0, 32'hDEADBEEF);

      // m1 preloads addr 1/2; leaves rr_last at 1 so m0 wins the contention below
      single(1'b1, 1'b1, 1, 32'h11, 32'd0);
      single(1'b1, 1'b1, 2, 32'h22, 32'd0);

      // Contention: both read for 8 cycles, grants alternate 0,1,0,1...
      c = cyc;
      drive(1'b0, 1'b1, 1'b0, 1, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 2, 32'd0);
      for (int k = 1; k <= 8; k++) begin
         push_g(c + k, k[0] ? 1'b0 : 1'b1, 1'b0, k[0] ? 1 : 2, 32'd0);
         push_r(c + k + 1, k[0] ? 1'b0 : 1'b1, k[0] ? 32'h11 : 32'h22);
      end
      repeat (8) tick();
      drive(1'b0, 1'b0, 1'b0, 0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 0, 32'd0);
      tick();

      // m1 alone holds a write for 6 cycles: grant every other cycle
      c = cyc;
      drive(1'b1, 1'b1, 1'b1, 3, 32'h33);
      push_g(c + 1, 1'b1, 1'b1, 3, 32'h33);
      push_g(c + 3, 1'b1, 1'b1, 3, 32'h33);
      push_g(c + 5, 1'b1, 1'b1, 3, 32'h33);
      repeat (6) tick();
      drive(1'b1, 1'b0, 1'b0, 0, 32'd0);

      // m0 write addr 7 followed immediately by m1 read of addr 7
      c = cyc;
      drive(1'b0, 1'b1, 1'b1, 7, 32'hA5A5A5A5);
      drive(1'b1, 1'b1, 1'b0, 7, 32'd0);
      push_g(c + 1, 1'b0, 1'b1, 7, 32'hA5A5A5A5);
      push_g(c + 2, 1'b1, 1'b0, 7, 32'd0);
      push_r(c + 3, 1'b1, 32'hA5A5A5A5);
      tick();
      tick();
      drive(1'b0, 1'b0, 1'b0, 0, 32'd0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 0, 32'd0);
      chk("m0_rdata_held", 64'(m0_rdata), 64'h11);
      tick();

      // Reset asserted in the middle of a write ACCESS cycle
      c = cyc;
      drive(1'b0, 1'b1, 1'b1, 9, 32'h1234);
      push_g(c + 1, 1'b0, 1'b1, 9, 32'h1234);
      tick();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 0, 32'd0);
      #1;
      chk("midrst_mem_rw", 64'(mem_rw), 64'd0);
      chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
      chk("midrst_m0_gnt", 64'(m0_gnt), 64'd0);
      chk("midrst_m1_gnt", 64'(m1_gnt), 64'd0);
      chk("midrst_m1_rdata", 64'(m1_rdata), 64'd0);
      repeat (2) tick();
      chk("midrst_mem9_unwritten", 64'(mem[9]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) tick();

      // After reset rr_last is 1 again, so m0 wins the first conflict
      c = cyc;
      drive(1'b0, 1'b1, 1'b0, 9, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 2, 32'd0);
      push_g(c + 1, 1'b0, 1'b0, 9, 32'd0);
      push_r(c + 2, 1'b0, 32'd0);
      push_g(c + 2, 1'b1, 1'b0, 2, 32'd0);
      push_r(c + 3, 1'b1, 32'h22);
      tick();
      tick();
      drive(1'b0, 1'b0, 1'b0, 0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 0, 32'd0);
      repeat (3) tick();

      chk("left_gnt", 64'(exp_g.size()), 64'd0);
      chk("left_r0", 64'(exp_r0.size()), 64'd0);
      chk("left_r1", 64'(exp_r1.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
